// File: rtl/evt2_stream_decoder_pkg.sv
`default_nettype none
// ============================================================================
// evt2_pkg : EVT 2.0 word type codes, field positions and the decoded event record
// Rev 1.0
// ============================================================================
package evt2_pkg;

    localparam logic [3:0] EVT_CD_OFF      = 4'h0;
    localparam logic [3:0] EVT_CD_ON       = 4'h1;
    localparam logic [3:0] EVT_TIME_HIGH   = 4'h8;
    localparam logic [3:0] EVT_EXT_TRIGGER = 4'hA;
    localparam logic [3:0] EVT_OTHERS      = 4'hE;
    localparam logic [3:0] EVT_CONTINUED   = 4'hF;

    localparam int TYPE_MSB   = 31;
    localparam int TYPE_LSB   = 28;
    localparam int TS_LSB_MSB = 27;
    localparam int TS_LSB_LSB = 22;
    localparam int X_MSB      = 21;
    localparam int X_LSB      = 11;
    localparam int Y_MSB      = 10;
    localparam int Y_LSB      = 0;
    localparam int TH_MSB     = 27;

    localparam int EVT_COORD_W = X_MSB - X_LSB + 1;
    localparam int EVT_TH_W    = TH_MSB + 1;
    localparam int EVT_TS_W    = EVT_TH_W + (TS_LSB_MSB - TS_LSB_LSB + 1);

    // Full-width record; the decoder narrows it to GRID_BITS / TS_BITS at the ports.
    typedef struct packed {
        logic [EVT_COORD_W-1:0] x;
        logic [EVT_COORD_W-1:0] y;
        logic                   pol;
        logic [EVT_TS_W-1:0]    ts;
    } evt2_event_t;

    function automatic logic [3:0] evt_type(input logic [31:0] word);
        return word[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt2_stream_decoder_if.sv
`default_nettype none
// ============================================================================
// evt2_stream_decoder_if : EVT 2.0 word input and decoded event output handshakes
// Rev 1.0
// ============================================================================
interface evt2_stream_decoder_if #(
    parameter int GRID_BITS = 4,
    parameter int TS_BITS   = 16
);
    logic [31:0]          data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic [GRID_BITS-1:0] ev_x;
    logic [GRID_BITS-1:0] ev_y;
    logic                 ev_pol;
    logic [TS_BITS-1:0]   ev_ts;
    logic                 ev_valid;
    logic                 ev_ready;

    modport master (
        output data_in, data_valid, ev_ready,
        input  data_ready, ev_x, ev_y, ev_pol, ev_ts, ev_valid
    );

    modport slave (
        input  data_in, data_valid, ev_ready,
        output data_ready, ev_x, ev_y, ev_pol, ev_ts, ev_valid
    );
endinterface
`default_nettype wire

// File: rtl/evt2_stream_decoder_out_fifo.sv
`default_nettype none
// ============================================================================
// evt2_out_fifo : 2-entry register FIFO of decoded events, count-based full/empty
// Rev 1.0
// ============================================================================
module evt2_out_fifo
    import evt2_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        push,
    input  wire evt2_event_t push_data,
    input  wire logic        pop,
    output evt2_event_t      head,
    output logic             full,
    output logic             empty
);

    evt2_event_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/evt2_stream_decoder.sv
`default_nettype none
// ============================================================================
// evt2_stream_decoder : EVT 2.0 decoder with 34-bit timestamp rebuild and grid downsampling
// Optional statistics counters: EVT2_DECODER_STATS_EN.  Rev 1.0
// ============================================================================
module evt2_stream_decoder
    import evt2_pkg::*;
#(
    parameter int SENSOR_W  = 320,
    parameter int SENSOR_H  = 320,
    parameter int GRID_BITS = 4,
    parameter int DS_SHIFT  = 4,
    parameter int CLAMP     = 1,
    parameter int TS_BITS   = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    evt2_stream_decoder_if.slave bus,
    output logic [15:0]          cnt_events,
    output logic [15:0]          cnt_dropped,
    output logic [15:0]          cnt_time_high,
    output logic [15:0]          cnt_other
);

    localparam logic [EVT_COORD_W-1:0] c_sensor_w = EVT_COORD_W'(SENSOR_W);
    localparam logic [EVT_COORD_W-1:0] c_sensor_h = EVT_COORD_W'(SENSOR_H);
    localparam logic [EVT_COORD_W-1:0] c_grid_max = EVT_COORD_W'((1 << GRID_BITS) - 1);
    localparam bit                     c_clamp_en = (CLAMP != 0);

    logic [EVT_TH_W-1:0]    r_time_high;
    logic [3:0]             w_type;
    logic [5:0]             w_ts_lsb;
    logic [EVT_COORD_W-1:0] w_x_raw;
    logic [EVT_COORD_W-1:0] w_y_raw;
    logic [EVT_COORD_W-1:0] w_gx;
    logic [EVT_COORD_W-1:0] w_gy;
    logic                   w_x_over;
    logic                   w_y_over;
    logic                   w_accept;
    logic                   w_is_cd;
    logic                   w_is_th;
    logic                   w_drop;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    evt2_event_t            w_event;
    evt2_event_t            w_head;
    logic                   w_unused_head;

    assign w_type   = evt_type(bus.data_in);
    assign w_ts_lsb = bus.data_in[TS_LSB_MSB:TS_LSB_LSB];
    assign w_x_raw  = bus.data_in[X_MSB:X_LSB];
    assign w_y_raw  = bus.data_in[Y_MSB:Y_LSB];
    assign w_gx     = w_x_raw >> DS_SHIFT;
    assign w_gy     = w_y_raw >> DS_SHIFT;
    assign w_x_over = (w_gx > c_grid_max);
    assign w_y_over = (w_gy > c_grid_max);

    assign w_accept = bus.data_valid && bus.data_ready;
    assign w_is_cd  = (w_type == EVT_CD_OFF) || (w_type == EVT_CD_ON);
    assign w_is_th  = (w_type == EVT_TIME_HIGH);
    assign w_drop   = (w_x_raw >= c_sensor_w) || (w_y_raw >= c_sensor_h) ||
                      (!c_clamp_en && (w_x_over || w_y_over));
    assign w_push   = w_accept && w_is_cd && !w_drop;
    assign w_pop    = !w_empty && bus.ev_ready;

    // The register is read combinationally, so a CD word in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_high <= '0;
        end else if (w_accept && w_is_th) begin
            r_time_high <= bus.data_in[TH_MSB:0];
        end
    end

    always_comb begin
        w_event     = '0;
        w_event.x   = w_x_over ? c_grid_max : w_gx;
        w_event.y   = w_y_over ? c_grid_max : w_gy;
        w_event.pol = (w_type == EVT_CD_ON);
        w_event.ts  = {r_time_high, w_ts_lsb};
    end

    evt2_out_fifo u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_event),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign bus.data_ready = !w_full;
    assign bus.ev_valid   = !w_empty;
    assign bus.ev_x       = w_head.x[GRID_BITS-1:0];
    assign bus.ev_y       = w_head.y[GRID_BITS-1:0];
    assign bus.ev_pol     = w_head.pol;
    assign bus.ev_ts      = w_head.ts[TS_BITS-1:0];
    assign w_unused_head  = ^w_head;

`ifdef EVT2_DECODER_STATS_EN
    logic [3:0]  w_inc;
    logic [15:0] r_cnt [4];

    assign w_inc[0] = w_push;
    assign w_inc[1] = w_accept && w_is_cd && w_drop;
    assign w_inc[2] = w_accept && w_is_th;
    assign w_inc[3] = w_accept && !w_is_cd && !w_is_th;

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[i] <= 16'd0;
            end else if (w_inc[i] && (r_cnt[i] != 16'hFFFF)) begin
                r_cnt[i] <= r_cnt[i] + 16'd1;
            end
        end
    end

    assign cnt_events    = r_cnt[0];
    assign cnt_dropped   = r_cnt[1];
    assign cnt_time_high = r_cnt[2];
    assign cnt_other     = r_cnt[3];
`else
    assign cnt_events    = 16'd0;
    assign cnt_dropped   = 16'd0;
    assign cnt_time_high = 16'd0;
    assign cnt_other     = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_evt2_stream_decoder.sv
`default_nettype none
// ============================================================================
// tb_evt2_stream_decoder : directed bench for evt2_stream_decoder (CLAMP=1 and CLAMP=0 instances)
// Rev 1.0
// ============================================================================
module tb_evt2_stream_decoder;

`ifdef EVT2_DECODER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] c0_ev, c0_dr, c0_th, c0_ot;
    logic [15:0] c1_ev, c1_dr, c1_th, c1_ot;

    always #5 clk = ~clk;

    evt2_stream_decoder_if #(.GRID_BITS(4), .TS_BITS(16)) bus0 ();
    evt2_stream_decoder_if #(.GRID_BITS(4), .TS_BITS(16)) bus1 ();

    evt2_stream_decoder #(.SENSOR_W(320), .SENSOR_H(320), .GRID_BITS(4), .DS_SHIFT(4),
                          .CLAMP(1), .TS_BITS(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .cnt_events(c0_ev), .cnt_dropped(c0_dr), .cnt_time_high(c0_th), .cnt_other(c0_ot)
    );

    evt2_stream_decoder #(.SENSOR_W(320), .SENSOR_H(320), .GRID_BITS(4), .DS_SHIFT(4),
                          .CLAMP(0), .TS_BITS(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .cnt_events(c1_ev), .cnt_dropped(c1_dr), .cnt_time_high(c1_th), .cnt_other(c1_ot)
    );

    task automatic set_ready(input logic r);
        bus0.ev_ready = r;
        bus1.ev_ready = r;
    endtask

    task automatic drive_word(input logic [31:0] w, input logic v);
        bus0.data_in = w; bus0.data_valid = v;
        bus1.data_in = w; bus1.data_valid = v;
    endtask

    task automatic do_reset();
        drive_word(32'h0, 1'b0);
        set_ready(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        drive_word(w, 1'b1);
        @(posedge clk);
        #1;
        drive_word(32'h0, 1'b0);
    endtask

    task automatic test_reset();
        drive_word(32'h0, 1'b0);
        set_ready(1'b0);
        rst_n = 1'b0;
        #2;
        checks++; if (bus0.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", bus0.ev_valid); end
        checks++; if (bus0.ev_x !== 4'd0 || bus0.ev_y !== 4'd0) begin failures++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", bus0.ev_x, bus0.ev_y); end
        checks++; if (bus0.ev_pol !== 1'b0 || bus0.ev_ts !== 16'd0) begin failures++; $display("FAIL reset_pol_ts: got %0b,%0d expected 0,0", bus0.ev_pol, bus0.ev_ts); end
        checks++; if ({c0_ev, c0_dr, c0_th, c0_ot} !== 64'd0) begin failures++; $display("FAIL reset_cnt: got %h expected 0", {c0_ev, c0_dr, c0_th, c0_ot}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus0.data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", bus0.data_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        send(32'h114320C8);
        checks++; if (bus0.ev_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b expected 1", bus0.ev_valid); end
        checks++; if (bus0.ev_x !== 4'd6 || bus0.ev_y !== 4'd12) begin failures++; $display("FAIL basic_xy: got %0d,%0d expected 6,12", bus0.ev_x, bus0.ev_y); end
        checks++; if (bus0.ev_pol !== 1'b1 || bus0.ev_ts !== 16'd5) begin failures++; $display("FAIL basic_pol_ts: got %0b,%0d expected 1,5", bus0.ev_pol, bus0.ev_ts); end
        checks++; if (c0_ev !== 16'(STATS)) begin failures++; $display("FAIL basic_cnt_events: got %0d expected %0d", c0_ev, STATS); end
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_ts !== 16'd5 || bus0.ev_x !== 4'd6) begin failures++; $display("FAIL basic_hold: got v=%0b x=%0d ts=%0d expected 1,6,5", bus0.ev_valid, bus0.ev_x, bus0.ev_ts); end
    endtask

    task automatic test_time_high();
        do_reset();
        send(32'h80000003);
        checks++; if (bus0.ev_valid !== 1'b0) begin failures++; $display("FAIL th_no_event: got %0b expected 0", bus0.ev_valid); end
        send(32'h114320C8);
        checks++; if (bus0.ev_ts !== 16'd197) begin failures++; $display("FAIL th_ts: got %0d expected 197", bus0.ev_ts); end
        checks++; if (c0_th !== 16'(STATS)) begin failures++; $display("FAIL th_cnt: got %0d expected %0d", c0_th, STATS); end
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        send(32'h8000FFFF);
        send(32'h114320C8);
        checks++; if (bus0.ev_ts !== 16'hFFC5) begin failures++; $display("FAIL th_trunc: got %h expected ffc5", bus0.ev_ts); end
    endtask

    task automatic test_clamp();
        do_reset();
        send(32'h0009F800);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd15 || bus0.ev_y !== 4'd0 || bus0.ev_pol !== 1'b0) begin failures++; $display("FAIL clamp_on: got v=%0b x=%0d y=%0d p=%0b expected 1,15,0,0", bus0.ev_valid, bus0.ev_x, bus0.ev_y, bus0.ev_pol); end
        checks++; if (bus1.ev_valid !== 1'b0) begin failures++; $display("FAIL clamp_off_drop: got %0b expected 0", bus1.ev_valid); end
        checks++; if (c1_dr !== 16'(STATS) || c0_dr !== 16'd0) begin failures++; $display("FAIL clamp_cnt_dropped: got %0d,%0d expected %0d,0", c1_dr, c0_dr, STATS); end
        send(32'h0007F800);
        checks++; if (bus1.ev_valid !== 1'b1 || bus1.ev_x !== 4'd15) begin failures++; $display("FAIL clamp_off_edge: got v=%0b x=%0d expected 1,15", bus1.ev_valid, bus1.ev_x); end
    endtask

    task automatic test_range();
        do_reset();
        send(32'h000A0000);
        checks++; if (bus0.ev_valid !== 1'b0 || bus0.data_ready !== 1'b1) begin failures++; $display("FAIL range_x: got v=%0b rdy=%0b expected 0,1", bus0.ev_valid, bus0.data_ready); end
        checks++; if (c0_dr !== 16'(STATS)) begin failures++; $display("FAIL range_cnt_x: got %0d expected %0d", c0_dr, STATS); end
        send(32'h00000140);
        checks++; if (bus0.ev_valid !== 1'b0 || c0_dr !== 16'(2 * STATS)) begin failures++; $display("FAIL range_y: got v=%0b cnt=%0d expected 0,%0d", bus0.ev_valid, c0_dr, 2 * STATS); end
        send(32'h0009F93F);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd15 || bus0.ev_y !== 4'd15) begin failures++; $display("FAIL range_max: got v=%0b x=%0d y=%0d expected 1,15,15", bus0.ev_valid, bus0.ev_x, bus0.ev_y); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send(32'h10408020);
        send(32'h00818040);
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b0 || bus0.ev_x !== 4'd1 || bus0.ev_ts !== 16'd1) begin failures++; $display("FAIL bp_full: got rdy=%0b x=%0d ts=%0d expected 0,1,1", bus0.data_ready, bus0.ev_x, bus0.ev_ts); end
        drive_word(32'h10C28060, 1'b1);
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b0 || bus0.ev_x !== 4'd1 || bus0.ev_y !== 4'd2) begin failures++; $display("FAIL bp_hold: got rdy=%0b x=%0d y=%0d expected 0,1,2", bus0.data_ready, bus0.ev_x, bus0.ev_y); end
        set_ready(1'b1);
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b1 || bus0.ev_x !== 4'd3 || bus0.ev_pol !== 1'b0 || bus0.ev_ts !== 16'd2) begin failures++; $display("FAIL bp_pop1: got rdy=%0b x=%0d p=%0b ts=%0d expected 1,3,0,2", bus0.data_ready, bus0.ev_x, bus0.ev_pol, bus0.ev_ts); end
        set_ready(1'b0);
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b0 || bus0.ev_x !== 4'd3) begin failures++; $display("FAIL bp_third_in: got rdy=%0b x=%0d expected 0,3", bus0.data_ready, bus0.ev_x); end
        drive_word(32'h0, 1'b0);
        set_ready(1'b1);
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd5 || bus0.ev_y !== 4'd6 || bus0.ev_ts !== 16'd3) begin failures++; $display("FAIL bp_third_out: got v=%0b x=%0d y=%0d ts=%0d expected 1,5,6,3", bus0.ev_valid, bus0.ev_x, bus0.ev_y, bus0.ev_ts); end
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b0 || c0_ev !== 16'(3 * STATS)) begin failures++; $display("FAIL bp_drained: got v=%0b cnt=%0d expected 0,%0d", bus0.ev_valid, c0_ev, 3 * STATS); end
        set_ready(1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ready(1'b1);
        @(negedge clk);
        drive_word(32'h10408020, 1'b1);
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd1) begin failures++; $display("FAIL b2b_first: got v=%0b x=%0d expected 1,1", bus0.ev_valid, bus0.ev_x); end
        drive_word(32'h00818040, 1'b1);
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd3 || bus0.data_ready !== 1'b1) begin failures++; $display("FAIL b2b_second: got v=%0b x=%0d rdy=%0b expected 1,3,1", bus0.ev_valid, bus0.ev_x, bus0.data_ready); end
        drive_word(32'h10C28060, 1'b1);
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd5) begin failures++; $display("FAIL b2b_third: got v=%0b x=%0d expected 1,5", bus0.ev_valid, bus0.ev_x); end
        drive_word(32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus0.ev_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %0b expected 0", bus0.ev_valid); end
        set_ready(1'b0);
    endtask

    task automatic test_others_and_reset();
        do_reset();
        send(32'hE0000000);
        send(32'h10408020);
        send(32'hA0000000);
        send(32'hF0000000);
        send(32'h00818040);
        checks++; if (c0_ot !== 16'(3 * STATS) || c0_ev !== 16'(2 * STATS)) begin failures++; $display("FAIL others_cnt: got other=%0d ev=%0d expected %0d,%0d", c0_ot, c0_ev, 3 * STATS, 2 * STATS); end
        checks++; if (bus0.ev_valid !== 1'b1 || bus0.ev_x !== 4'd1 || bus0.data_ready !== 1'b0) begin failures++; $display("FAIL others_head: got v=%0b x=%0d rdy=%0b expected 1,1,0", bus0.ev_valid, bus0.ev_x, bus0.data_ready); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.ev_valid !== 1'b0 || bus0.ev_x !== 4'd0 || bus0.data_ready !== 1'b1) begin failures++; $display("FAIL midreset: got v=%0b x=%0d rdy=%0b expected 0,0,1", bus0.ev_valid, bus0.ev_x, bus0.data_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_time_high();
        test_clamp();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_others_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
